// File: rtl/prog_loader.sv
// Boot-time program loader: receives a byte stream, writes 9-bit instructions into
// the instruction memory write port, starts the core and measures its run length.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for load_req after reset
// HDR_LO  | expecting instruction count bits [7:0]
// HDR_HI  | expecting instruction count bits [11:8] (upper nibble must be 0)
// INS_LO  | expecting instruction code bits [7:0]
// INS_HI  | expecting instruction code bit 8 (bits [7:1] ignored)
// START   | holding cpu_start high for START_CYCLES cycles
// RUN     | counting cycles until cpu_done
// DONE    | program finished, run_cycles held; a new load may begin
// ERROR   | malformed header; left only through reset
module prog_loader #(
    parameter int D            = 12,
    parameter int START_CYCLES = 2,
    parameter int CW           = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_req,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          im_wr_en,
    output logic [D-1:0]  im_wr_addr,
    output logic [8:0]    im_wr_data,
    output logic          cpu_start,
    input  logic          cpu_done,
    output logic          busy,
    output logic          finished,
    output logic          error,
    output logic [CW-1:0] run_cycles
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_LO, S_HDR_HI, S_INS_LO, S_INS_HI,
        S_START, S_RUN, S_DONE, S_ERROR
    } state_t;

    // Start-pulse down-counter needs to hold START_CYCLES-1.
    localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);

    state_t         state, state_nxt;
    logic [11:0]    count;
    logic [D-1:0]   index;
    logic [D:0]     idx_inc;
    logic [7:0]     lo_byte;
    logic [SCW-1:0] start_cnt;
    logic           beat;
    logic           last_ins;

    assign beat     = in_valid & in_ready;
    assign idx_inc  = {1'b0, index} + {{D{1'b0}}, 1'b1};
    assign last_ins = (idx_inc == (D+1)'(count));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        cpu_start = 1'b0;
        busy      = 1'b1;
        finished  = 1'b0;
        error     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (load_req) state_nxt = S_HDR_LO;
            end
            S_HDR_LO: begin
                in_ready = 1'b1;
                if (beat) state_nxt = S_HDR_HI;
            end
            S_HDR_HI: begin
                in_ready = 1'b1;
                if (beat) begin
                    if (in_data[7:4] != 4'd0)
                        state_nxt = S_ERROR;
                    else if ({in_data[3:0], count[7:0]} == 12'd0)
                        state_nxt = S_START;
                    else
                        state_nxt = S_INS_LO;
                end
            end
            S_INS_LO: begin
                in_ready = 1'b1;
                if (beat) state_nxt = S_INS_HI;
            end
            S_INS_HI: begin
                in_ready = 1'b1;
                if (beat) state_nxt = last_ins ? S_START : S_INS_LO;
            end
            S_START: begin
                cpu_start = 1'b1;
                if (start_cnt == '0) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (cpu_done) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy     = 1'b0;
                finished = 1'b1;
                if (load_req) state_nxt = S_HDR_LO;
            end
            S_ERROR: begin
                busy  = 1'b0;
                error = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Header capture, instruction write strobe, start timer and run counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            index      <= '0;
            lo_byte    <= '0;
            im_wr_en   <= 1'b0;
            im_wr_addr <= '0;
            im_wr_data <= '0;
            start_cnt  <= START_LAST;
            run_cycles <= '0;
        end else begin
            im_wr_en  <= 1'b0;
            start_cnt <= (state == S_START) ? start_cnt - SCW'(1) : START_LAST;
            case (state)
                S_IDLE, S_DONE: begin
                    if (load_req) begin
                        run_cycles <= '0;
                        index      <= '0;
                    end
                end
                S_HDR_LO: if (beat) count[7:0]  <= in_data;
                S_HDR_HI: if (beat) count[11:8] <= in_data[3:0];
                S_INS_LO: if (beat) lo_byte     <= in_data;
                S_INS_HI: begin
                    if (beat) begin
                        im_wr_en   <= 1'b1;
                        im_wr_addr <= index;
                        im_wr_data <= {in_data[0], lo_byte};
                        index      <= idx_inc[D-1:0];
                    end
                end
                S_RUN: begin
                    if (!cpu_done && run_cycles != '1)
                        run_cycles <= run_cycles + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and randomized program streams,
// compared against a list-based model of expected writes and run lengths.
module tb_prog_loader;

    localparam int D  = 12;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_req = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_valid = 1'b0;
    logic          cpu_done = 1'b0;
    logic          in_ready, im_wr_en, cpu_start, busy, finished, error;
    logic [D-1:0]  im_wr_addr;
    logic [8:0]    im_wr_data;
    logic [CW-1:0] run_cycles;

    logic          in_ready_b, im_wr_en_b, cpu_start_b, busy_b, finished_b, error_b;
    logic [D-1:0]  im_wr_addr_b;
    logic [8:0]    im_wr_data_b;
    logic [3:0]    run_cycles_b;

    prog_loader #(.D(D), .START_CYCLES(2), .CW(CW)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .im_wr_en(im_wr_en),
        .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data), .cpu_start(cpu_start),
        .cpu_done(cpu_done), .busy(busy), .finished(finished), .error(error),
        .run_cycles(run_cycles)
    );

    // Narrow-counter instance sharing all stimulus, for saturation checks.
    prog_loader #(.D(D), .START_CYCLES(2), .CW(4)) dut_cw4 (
        .clk(clk), .reset(reset), .load_req(load_req), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready_b), .im_wr_en(im_wr_en_b),
        .im_wr_addr(im_wr_addr_b), .im_wr_data(im_wr_data_b), .cpu_start(cpu_start_b),
        .cpu_done(cpu_done), .busy(busy_b), .finished(finished_b), .error(error_b),
        .run_cycles(run_cycles_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_viol = 0;

    logic [20:0] got_w[$];
    int          got_wc[$];
    logic [20:0] exp_w[$];
    int          exp_wc[$];
    logic [8:0]  prog[$];
    bit          hi_junk = 1'b0;

    // Cycle counter used to time write strobes against their HI beats.
    always @(posedge clk) cyc <= cyc + 1;

    // Capture writes and watch for in_ready outside the load states.
    always @(negedge clk) begin
        if (im_wr_en) begin
            got_w.push_back({im_wr_addr, im_wr_data});
            got_wc.push_back(cyc);
        end
        if (in_ready && (cpu_start || finished || error || !busy))
            ready_viol++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap, input bit is_hi_ins);
        int g;
        int n;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        in_valid = 1'b0;
        repeat (g) tick();
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("beat_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        if (is_hi_ins) exp_wc.push_back(cyc + 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Sends header and instructions from prog; stops after stop_after
    // instructions when stop_after > 0.
    task automatic load_stream(input int maxgap, input int stop_after);
        logic [11:0] cnt;
        logic [6:0]  junk;
        got_w.delete(); got_wc.delete(); exp_w.delete(); exp_wc.delete();
        cnt = 12'(prog.size());
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        send_byte(cnt[7:0], maxgap, 1'b0);
        send_byte({4'd0, cnt[11:8]}, maxgap, 1'b0);
        for (int i = 0; i < prog.size(); i++) begin
            junk = hi_junk ? 7'($urandom) : 7'd0;
            send_byte(prog[i][7:0], maxgap, 1'b0);
            send_byte({junk, prog[i][8]}, maxgap, 1'b1);
            exp_w.push_back({12'(i), prog[i]});
            if (i + 1 == stop_after) return;
        end
    endtask

    task automatic check_writes();
        chk("n_writes", got_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            chk("wr_addr_data", got_w[i], exp_w[i]);
            chk("wr_latency", got_wc[i], exp_wc[i]);
        end
    endtask

    // Called right after the last load beat; the core "finishes" after delay RUN cycles.
    task automatic run_phase(input int delay, input bit done_early);
        int n;
        int starts;
        n = 0;
        starts = 0;
        if (done_early) cpu_done = 1'b1;
        chk("start_asserted", cpu_start, 1);
        chk("not_finished_in_start", finished, 0);
        while (cpu_start && n < 20) begin
            starts++;
            tick();
            n++;
        end
        chk("start_len", starts, 2);
        chk("busy_in_run", busy, 1);
        for (int i = 0; i < delay; i++) tick();
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        chk("finished", finished, 1);
        chk("busy_done", busy, 0);
        chk("run_cycles", run_cycles, delay);
        chk("run_cycles_cw4", run_cycles_b, (delay > 15) ? 15 : delay);
        repeat (3) tick();
        chk("run_cycles_held", run_cycles, delay);
    endtask

    task automatic set_test1();
        prog.delete();
        prog.push_back(9'h112);
        prog.push_back(9'h034);
        prog.push_back(9'h1FF);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", im_wr_en, 0);
        chk("rst_cpu_start", cpu_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finished", finished, 0);
        chk("rst_error", error, 0);
        chk("rst_addr", im_wr_addr, 0);
        chk("rst_data", im_wr_data, 0);
        chk("rst_run_cycles", run_cycles, 0);
        reset = 1'b0;
        tick();

        // Basic three-instruction program, back-to-back bytes.
        set_test1();
        load_stream(0, 0);
        run_phase(37, 1'b0);
        check_writes();

        // Empty program goes straight to START.
        prog.delete();
        load_stream(0, 0);
        run_phase(5, 1'b0);
        check_writes();

        // Same program with valid gaps and junk in HI bits; run long enough to saturate CW=4.
        set_test1();
        hi_junk = 1'b1;
        load_stream(5, 0);
        run_phase(40, 1'b0);
        check_writes();
        hi_junk = 1'b0;

        // Malformed header locks into ERROR until reset.
        got_w.delete();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        send_byte(8'h05, 0, 1'b0);
        send_byte(8'h10, 0, 1'b0);
        chk("err_flag", error, 1);
        chk("err_in_ready", in_ready, 0);
        chk("err_busy", busy, 0);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        repeat (3) tick();
        chk("err_sticky", error, 1);
        chk("err_in_ready2", in_ready, 0);
        chk("err_no_writes", got_w.size(), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("err_cleared", error, 0);

        // Reset after the 2nd instruction: only two writes, then a clean reload works.
        set_test1();
        load_stream(0, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_wr_en", im_wr_en, 0);
        chk("mid_rst_run_cycles", run_cycles, 0);
        tick();
        check_writes();
        load_stream(0, 0);
        run_phase(0, 1'b1);
        check_writes();

        // Randomized programs, gaps and run lengths.
        hi_junk = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int sz;
            prog.delete();
            sz = int'($urandom_range(8, 1));
            for (int i = 0; i < sz; i++) prog.push_back(9'($urandom));
            load_stream(3, 0);
            run_phase(int'($urandom_range(50, 0)), 1'b0);
            check_writes();
        end

        chk("ready_outside_load", ready_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
